fetch_unit: RTL and testbench

- Instruction fetch stage. Owns the program counter and issues word-addressed reads to main_memory.
- Buffers returned instruction words, tagged with their PC, in a small prefetch FIFO.
- Presents the buffered words to the downstream decode stage over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all fetched-but-unconsumed work.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC
// and the fetch-to-decode entry layout.
package cpu_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   localparam logic [ADDR_WIDTH-1:0] PC_RESET_DEFAULT = 32'h0;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] data;
   } fetch_entry_t;

   function automatic logic [ADDR_WIDTH-1:0] pc_next(
      input logic [ADDR_WIDTH-1:0] pc
   );
      return pc + 1'b1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a
// show-ahead head output; zero head when empty.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case (1'b1)
            (do_push && !do_pop): cnt <= cnt + 1'b1;
            (do_pop && !do_push): cnt <= cnt - 1'b1;
            default:              cnt <= cnt;
         endcase
      end
   end

   // Storage has no reset; head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited issue to
// 1-cycle memory, prefetch FIFO and redirect flush.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = PC_RESET_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_read_en,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   input  logic [WORD_WIDTH-1:0] mem_read_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [WORD_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [ADDR_WIDTH-1:0] fetch_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic                  inflight;
   logic [CW-1:0]         count;
   logic [CW:0]           credit_used;
   logic                  full;
   logic                  empty;
   logic                  issue;
   logic                  push;
   logic                  pop;
   fetch_entry_t          push_entry;
   fetch_entry_t          head_entry;

   // Occupancy before any same-cycle pop: conservative.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign issue = rst && !redirect_valid
               && (credit_used < (CW+1)'(DEPTH));

   assign push = inflight && !redirect_valid;
   assign instr_valid = !empty && !redirect_valid;
   assign pop = instr_valid && instr_ready;

   assign mem_read_en      = issue;
   assign mem_read_address = pc;
   assign fetch_pc         = pc;

   assign push_entry.pc   = req_pc;
   assign push_entry.data = mem_read_data;
   assign instr_pc   = head_entry.pc;
   assign instr_data = head_entry.data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         unique case (1'b1)
            redirect_valid: begin
               pc       <= redirect_pc;
               inflight <= 1'b0;
            end
            issue: begin
               pc       <= pc_next(pc);
               req_pc   <= pc;
               inflight <= 1'b1;
            end
            default: inflight <= 1'b0;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (head_entry)
   );

   push_never_full: assert property (
      @(posedge clk) disable iff (!rst) !(push && full)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against
// a transaction-level model of the fetch stream.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_en;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic [31:0] fetch_pc;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_pc;
   logic [31:0] iss_pc;
   int          n_out;
   logic        obs_en;
   logic        obs_valid;
   logic [31:0] obs_addr;
   logic [31:0] obs_pc;
   logic [31:0] obs_data;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .mem_read_en      (mem_read_en),
      .mem_read_address (mem_read_address),
      .mem_read_data    (mem_read_data),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr_data       (instr_data),
      .instr_pc         (instr_pc),
      .fetch_pc         (fetch_pc)
   );

   // Memory image: mem[a] = a + 0x100, one-cycle latency.
   always @(posedge clk)
      mem_read_data <= mem_read_en ? mem_read_address + 32'h100
                                   : 32'hDEAD_BEEF;

   task automatic chk(input string tag,
                      input logic [31:0] o,
                      input logic [31:0] e);
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic release_rst();
      rst    = 1'b1;
      exp_pc = 32'h0;
      iss_pc = 32'h0;
      n_out  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      release_rst();
   endtask

   // One clock cycle with the current inputs, checked by the model.
   task automatic cycle();
      #1;
      obs_en    = mem_read_en;
      obs_valid = instr_valid;
      obs_addr  = mem_read_address;
      obs_pc    = instr_pc;
      obs_data  = instr_data;
      if (mem_read_en) begin
         chk("issue_addr", mem_read_address, iss_pc);
         iss_pc++;
         n_out++;
      end
      if (instr_valid) begin
         chk("head_pc", instr_pc, exp_pc);
         chk("head_data", instr_data, exp_pc + 32'h100);
      end
      if (instr_valid && instr_ready) begin
         exp_pc++;
         n_out--;
      end
      if (redirect_valid) begin
         chk("redir_quiet", {30'b0, mem_read_en, instr_valid}, 32'h0);
         exp_pc = redirect_pc;
         iss_pc = redirect_pc;
         n_out  = 0;
      end
      chk("credit", 32'(n_out <= 4), 32'h1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_en"},    32'(mem_read_en), 32'h0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
      chk({tag, "_data"},  instr_data, 32'h0);
      chk({tag, "_pc"},    instr_pc, 32'h0);
      chk({tag, "_fpc"},   fetch_pc, 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      #2;
      chk_reset_outputs("rst0");

      // Streaming from reset
      instr_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("t1_addr", obs_addr, 32'(k));
         chk("t1_en", 32'(obs_en), 32'h1);
         chk("t1_valid", 32'(obs_valid), 32'(k >= 2));
         if (k >= 2) begin
            chk("t1_pc", obs_pc, 32'(k - 2));
            chk("t1_data", obs_data, 32'(k - 2) + 32'h100);
         end
      end

      // Stalled decode fills the FIFO, then drains in order
      instr_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("t2_en", 32'(obs_en), 32'(k < 4));
      end
      chk("t2_full_valid", 32'(obs_valid), 32'h1);
      chk("t2_full_pc", obs_pc, 32'h0);
      instr_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t2_valid", 32'(obs_valid), 32'h1);
         chk("t2_pc", obs_pc, 32'(k));
      end

      // Redirect with 3 queued and 1 in flight
      instr_ready = 1'b0;
      do_reset();
      repeat (4) cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      instr_ready = 1'b1;
      cycle();
      chk("t3_r_valid", 32'(obs_valid), 32'h0);
      redirect_valid = 1'b0;
      cycle();
      chk("t3_r1_valid", 32'(obs_valid), 32'h0);
      chk("t3_r1_addr", obs_addr, 32'h40);
      chk("t3_r1_en", 32'(obs_en), 32'h1);
      cycle();
      chk("t3_r2_valid", 32'(obs_valid), 32'h0);
      cycle();
      chk("t3_r3_valid", 32'(obs_valid), 32'h1);
      chk("t3_r3_pc", obs_pc, 32'h40);
      chk("t3_r3_data", obs_data, 32'h140);
      repeat (3) cycle();

      // Asynchronous reset mid-cycle
      #3;
      rst = 1'b0;
      #1;
      chk_reset_outputs("t4_async");
      @(posedge clk);
      #1;
      chk_reset_outputs("t4_hold");
      release_rst();
      cycle();
      cycle();
      chk("t4_c1_valid", 32'(obs_valid), 32'h0);
      cycle();
      chk("t4_c2_valid", 32'(obs_valid), 32'h1);
      chk("t4_c2_pc", obs_pc, 32'h0);
      chk("t4_c2_data", obs_data, 32'h100);

      // PC wrap
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      cycle();
      redirect_valid = 1'b0;
      repeat (3) cycle();
      chk("t5_pc0", obs_pc, 32'hFFFF_FFFF);
      chk("t5_data0", obs_data, 32'h0000_00FF);
      cycle();
      chk("t5_pc1", obs_pc, 32'h0);
      chk("t5_data1", obs_data, 32'h100);
      cycle();
      chk("t5_pc2", obs_pc, 32'h1);
      chk("t5_data2", obs_data, 32'h101);

      // Back-to-back redirects
      redirect_valid = 1'b1;
      redirect_pc = 32'h10;
      cycle();
      redirect_pc = 32'h20;
      cycle();
      chk("t6_r1_valid", 32'(obs_valid), 32'h0);
      redirect_valid = 1'b0;
      cycle();
      chk("t6_r2_valid", 32'(obs_valid), 32'h0);
      chk("t6_r2_addr", obs_addr, 32'h20);
      cycle();
      chk("t6_r3_valid", 32'(obs_valid), 32'h0);
      cycle();
      chk("t6_r4_valid", 32'(obs_valid), 32'h1);
      chk("t6_r4_pc", obs_pc, 32'h20);
      chk("t6_r4_data", obs_data, 32'h120);

      // Random ready and redirects
      for (int k = 0; k < 400; k++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0)
                     ? 32'hFFFF_FFFE : $urandom;
         cycle();
      end
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      repeat (8) cycle();

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
